// File: rtl/quad_decoder_counter_8bit.sv
// Quadrature front end: synchronises and glitch-filters two encoder phases,
// decodes Gray-code steps into step/dir pulses, keeps a wrapping count and flags double-phase jumps.
module quad_decoder_counter_8bit #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             enable,
    input  logic             clear,
    input  logic             err_clr,
    output logic             step_o,
    output logic             dir_o,
    output logic [WIDTH-1:0] count_o,
    output logic             err_o
);

    // Run and stability counters only need to reach FILTER_LEN-1.
    localparam int RW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [SYNC_STAGES-1:0]      valid_q;
    logic [1:0]                  ph;
    logic [1:0]                  filt_q, filt_d;
    logic [1:0][RW-1:0]          run_q, run_d;
    logic [RW-1:0]               stab_q, stab_d;
    logic                        primed_q, primed_d;
    logic [1:0]                  prev_q, prev_d;
    logic                        step_q, step_d;
    logic                        dir_q, dir_d;
    logic                        err_q, err_d;
    logic [WIDTH-1:0]            count_q, count_d;
    logic                        illegal, legal, up, adv;

    // Bit 1 carries phase A, bit 0 phase B.
    assign ph = sync_q[SYNC_STAGES-1];

    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (ph[i] != filt_q[i]) begin
                if (run_q[i] == RUN_LAST) begin
                    filt_d[i] = ph[i];
                end else begin
                    run_d[i] = run_q[i] + RW'(1);
                end
            end
        end
    end

    // Priming waits for the synchroniser to fill, so reset-time zeros never count as stable.
    always_comb begin
        stab_d   = '0;
        primed_d = primed_q;
        prev_d   = prev_q;
        if (!primed_q) begin
            if (valid_q[SYNC_STAGES-1] && (ph == filt_q)) begin
                if (stab_q == RUN_LAST) begin
                    primed_d = 1'b1;
                    prev_d   = filt_q;
                end else begin
                    stab_d = stab_q + RW'(1);
                end
            end
        end else begin
            prev_d = filt_q;
        end
    end

    assign illegal = primed_q && ((filt_q ^ prev_q) == 2'b11);
    assign legal   = primed_q && ((filt_q[1] ^ prev_q[1]) != (filt_q[0] ^ prev_q[0]));
    assign up      = prev_q[0] ^ filt_q[1];
    assign adv     = legal && enable;

    always_comb begin
        step_d  = adv;
        dir_d   = adv ? up : dir_q;
        count_d = count_q;
        if (adv) begin
            count_d = up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        end
        if (clear) begin
            count_d = '0;
        end
        err_d = err_q;
        if (illegal) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q   <= '0;
            valid_q  <= '0;
            filt_q   <= '0;
            run_q    <= '0;
            stab_q   <= '0;
            primed_q <= 1'b0;
            prev_q   <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], {quad_a, quad_b}};
            valid_q  <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            filt_q   <= filt_d;
            run_q    <= run_d;
            stab_q   <= stab_d;
            primed_q <= primed_d;
            prev_q   <= prev_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign step_o  = step_q;
    assign dir_o   = dir_q;
    assign count_o = count_q;
    assign err_o   = err_q;

endmodule
